// File: rtl/eth_rx_frame_fifo_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
//   Shared definitions for the RX store-and-forward frame buffer.
//   - wr_state_t      : write-side frame FSM states.
//   - ram_ctrl_t      : sideband bits stored above the data byte in each RAM
//                       word ({tuser, tlast, tdata}).
//   - ram_word_width(): RAM word width for a given stream data width.
// -----------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FRAME = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

    // Sideband bits stored in the top of every RAM word.
    typedef struct packed {
        logic tuser;
        logic tlast;
    } ram_ctrl_t;

    localparam int unsigned RAM_CTRL_BITS = $bits(ram_ctrl_t);

    function automatic int unsigned ram_word_width(input int unsigned data_width);
        return data_width + RAM_CTRL_BITS;
    endfunction

endpackage

// File: rtl/eth_rx_frame_fifo_sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
//   Simple dual-port RAM, one write port and one read port on a single clock.
//   Read data is registered and only updates when rd_en_i is high, so the
//   output word holds while the reader is stalled. No reset on the array or
//   the read register so that the structure maps onto block RAM.
//
// Ports
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe (registered read)
//   rd_addr_i  : read address
//   rd_data_o  : read data, valid the cycle after rd_en_i
// -----------------------------------------------------------------------------
module sdp_ram #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// -----------------------------------------------------------------------------
// eth_rx_frame_fifo
//   Store-and-forward receive frame buffer behind the RX MAC AXI-Stream output.
//   Bytes are written speculatively at wr_ptr; a frame becomes visible to the
//   reader only when its last byte is accepted and commit_ptr advances. Frames
//   that hit a full buffer are discarded whole by rewinding wr_ptr to
//   commit_ptr, so the consumer never sees a truncated frame.
//
// Configuration
//   RX_FIFO_DROP_BAD_EN : when defined, frames whose last byte carries tuser=1
//                         are rewound instead of committed and bad_frame_drop
//                         pulses. When undefined, bad frames are delivered with
//                         m_axis_tuser=1 on their last byte and bad_frame_drop
//                         is tied low.
//
// Ports
//   clk, reset         : single clock, synchronous active-high reset
//   s_rx_axis_*        : input stream from the MAC (trdy high outside reset)
//   m_axis_*           : first-word-fall-through output stream
//   overflow_drop      : one-cycle pulse, frame discarded because buffer full
//   bad_frame_drop     : one-cycle pulse, frame discarded because of tuser
// -----------------------------------------------------------------------------
module eth_rx_frame_fifo
    import eth_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4096,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s_rx_axis_tdata,
    input  logic                  s_rx_axis_tvalid,
    input  logic                  s_rx_axis_tlast,
    input  logic                  s_rx_axis_tuser,
    output logic                  s_rx_axis_trdy,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_trdy,

    output logic                  overflow_drop,
    output logic                  bad_frame_drop
);

    localparam int unsigned WORD_W = ram_word_width(DATA_WIDTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_t             wr_state_q;
    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic [ADDR_WIDTH:0]   commit_ptr_q;
    logic [ADDR_WIDTH:0]   rd_ptr_q;
    logic [ADDR_WIDTH:0]   wr_ptr_inc;
    logic                  trdy_q;
    logic                  ovf_q;
    logic                  bad_q;
    logic                  beat;
    logic                  full;
    logic                  ram_we;
    logic [WORD_W-1:0]     ram_wr_word;

    assign beat       = s_rx_axis_tvalid & trdy_q;
    assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
    assign full       = (wr_ptr_q - rd_ptr_q) == DEPTH_PTR;
    assign ram_we     = beat & ~full & (wr_state_q != WR_DROP);

    always_comb begin
        ram_wr_word = {s_rx_axis_tuser, s_rx_axis_tlast, s_rx_axis_tdata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q   <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            trdy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            trdy_q <= 1'b1;
            ovf_q  <= 1'b0;
            bad_q  <= 1'b0;
            if (beat) begin
                case (wr_state_q)
                    WR_IDLE, WR_FRAME: begin
                        if (full) begin
                            // Discard everything written for this frame; a
                            // full buffer on its last byte needs no drop state.
                            wr_ptr_q   <= commit_ptr_q;
                            ovf_q      <= 1'b1;
                            wr_state_q <= s_rx_axis_tlast ? WR_IDLE : WR_DROP;
                        end else if (s_rx_axis_tlast) begin
                            wr_state_q <= WR_IDLE;
`ifdef RX_FIFO_DROP_BAD_EN
                            if (s_rx_axis_tuser) begin
                                wr_ptr_q <= commit_ptr_q;
                                bad_q    <= 1'b1;
                            end else begin
                                wr_ptr_q     <= wr_ptr_inc;
                                commit_ptr_q <= wr_ptr_inc;
                            end
`else
                            wr_ptr_q     <= wr_ptr_inc;
                            commit_ptr_q <= wr_ptr_inc;
`endif
                        end else begin
                            wr_ptr_q   <= wr_ptr_inc;
                            wr_state_q <= WR_FRAME;
                        end
                    end
                    WR_DROP: begin
                        if (s_rx_axis_tlast) begin
                            wr_state_q <= WR_IDLE;
                        end
                    end
                    default: begin
                        wr_state_q <= WR_IDLE;
                    end
                endcase
            end
        end
    end

    assign s_rx_axis_trdy = trdy_q;
    assign overflow_drop  = ovf_q;
`ifdef RX_FIFO_DROP_BAD_EN
    assign bad_frame_drop = bad_q;
`else
    assign bad_frame_drop = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic              ram_re;
    logic [WORD_W-1:0] ram_rd_word;

    sdp_ram #(
        .WIDTH      (WORD_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (ram_wr_word),
        .rd_en_i   (ram_re),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_word)
    );

    // ------------------------------------------------------------------
    // Read side
    //   Two-stage pipe: the RAM read register (valid = ram_vld_q) feeds the
    //   output register. The RAM register only reloads when its word moves
    //   into the output register, so it doubles as the skid stage and keeps
    //   one byte per cycle under sustained ready.
    // ------------------------------------------------------------------
    logic                  empty;
    logic                  load_out;
    logic                  ram_vld_q;
    logic                  ram_vld_d;
    logic [ADDR_WIDTH:0]   rd_ptr_d;
    logic                  out_vld_q;
    logic                  out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;
    ram_ctrl_t             out_ctrl_q;
    ram_ctrl_t             out_ctrl_d;

    // commit_ptr_q is the registered value, so a same-cycle commit is only
    // seen by the reader on the following cycle.
    assign empty    = (rd_ptr_q == commit_ptr_q);
    assign load_out = ram_vld_q & (~out_vld_q | m_axis_trdy);
    assign ram_re   = ~empty & (~ram_vld_q | load_out);

    always_comb begin
        rd_ptr_d   = ram_re ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ram_vld_d  = ram_re | (ram_vld_q & ~load_out);
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        if (load_out) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rd_word[DATA_WIDTH-1:0];
            out_ctrl_d = ram_ctrl_t'(ram_rd_word[WORD_W-1 -: RAM_CTRL_BITS]);
        end else if (m_axis_trdy) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            ram_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            ram_vld_q  <= ram_vld_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
        end
    end

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_ctrl_q.tlast;
    assign m_axis_tuser  = out_ctrl_q.tuser;

endmodule
